// File: rtl/counter_arbiter_pkg.sv
// Shared types and constants for the counter_arbiter round-robin accumulator sequencer.
package counter_arbiter_pkg;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_STAT_W = 8;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ISSUE,
        SETTLE,
        CLEAR
    } state_t;

    // Index width for NREQ requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// Combinational round-robin select: first set request strictly after pointer, wrapping.
module rr_pick
    import counter_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] pointer,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NREQ);

    logic [NREQ-1:0]  hit;
    logic [IDX_W-1:0] cand [NREQ];

    // cand[k] is the requester k+1 positions after the pointer, modulo NREQ.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        logic [IDX_W:0] wrapped;
        assign sum      = {1'b0, pointer} + (IDX_W+1)'(gi + 1);
        assign wrapped  = (sum >= NREQ_W) ? (sum - NREQ_W) : sum;
        assign cand[gi] = wrapped[IDX_W-1:0];
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                index = cand[k];
                valid = 1'b1;
            end
        end
        grant = valid ? (NREQ'(1) << index) : '0;
    end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin sequencer sharing one accumulating counter among NREQ requesters.
// Define COUNTER_ARBITER_STATS_EN to add saturating per-requester grant counters (gnt_cnt).
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
`ifdef COUNTER_ARBITER_STATS_EN
    , parameter int STAT_W = DEF_STAT_W
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      req_val,
    output logic [NREQ-1:0]            gnt,
    input  logic                       clr_req,
    output logic                       acc_reset,
    output logic [WIDTH-1:0]           acc_in,
    input  logic [WIDTH-1:0]           acc_out,
    output logic                       busy,
    output logic                       wrap,
    output logic [idx_w(NREQ)-1:0]     last_id
`ifdef COUNTER_ARBITER_STATS_EN
    , output logic [NREQ*STAT_W-1:0]   gnt_cnt
`endif
);

    localparam int IDX_W = idx_w(NREQ);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] last_id_reg;
    logic             carry_reg;
    logic             wrap_reg;
    logic             clr_pend_reg;

    logic [NREQ-1:0]  win_gnt;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic [WIDTH-1:0] val_arr [NREQ];
    logic [WIDTH:0]   acc_sum;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_val
        assign val_arr[gi] = req_val[gi*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .pointer (ptr_reg),
        .grant   (win_gnt),
        .index   (win_idx),
        .valid   (win_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= INIT;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT:   state_next = IDLE;
            IDLE: begin
                if (clr_req || clr_pend_reg) state_next = CLEAR;
                else if (|req)               state_next = ISSUE;
            end
            ISSUE:  state_next = SETTLE;
            SETTLE: state_next = IDLE;
            CLEAR:  state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    // Carry out of the pending accumulation, evaluated one bit wider than the counter.
    assign acc_sum = {1'b0, acc_out} + {1'b0, acc_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg      <= IDX_W'(NREQ - 1);
            last_id_reg  <= '0;
            carry_reg    <= 1'b0;
            wrap_reg     <= 1'b0;
            clr_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                ISSUE: begin
                    carry_reg <= acc_sum[WIDTH];
                    if (win_valid) begin
                        ptr_reg     <= win_idx;
                        last_id_reg <= win_idx;
                    end
                end
                SETTLE: if (carry_reg) wrap_reg <= 1'b1;
                CLEAR:  wrap_reg <= 1'b0;
                default: ;
            endcase
            // A clear arriving during CLEAR itself is absorbed by that CLEAR.
            if (state_reg == CLEAR)
                clr_pend_reg <= 1'b0;
            else if (clr_req && (state_reg == ISSUE || state_reg == SETTLE))
                clr_pend_reg <= 1'b1;
        end
    end

    always_comb begin
        gnt       = '0;
        acc_in    = '0;
        acc_reset = 1'b0;
        busy      = 1'b1;
        case (state_reg)
            INIT:  acc_reset = 1'b1;
            IDLE:  busy = 1'b0;
            ISSUE: begin
                gnt = win_gnt;
                if (win_valid) acc_in = val_arr[win_idx];
            end
            CLEAR: acc_reset = 1'b1;
            default: ;
        endcase
    end

    assign wrap    = wrap_reg;
    assign last_id = last_id_reg;

`ifdef COUNTER_ARBITER_STATS_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
        logic [STAT_W-1:0] cnt_reg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                cnt_reg <= '0;
            else if (state_reg == CLEAR)
                cnt_reg <= '0;
            else if (gnt[gi] && (cnt_reg != '1))
                cnt_reg <= cnt_reg + 1'b1;
        end
        assign gnt_cnt[gi*STAT_W +: STAT_W] = cnt_reg;
    end
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// Randomized and directed bench for counter_arbiter with a behavioural arbitration/accumulator model.
module tb_counter_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_val;
    logic [3:0]  gnt;
    logic        clr_req;
    logic        acc_reset;
    logic [3:0]  acc_in;
    logic [3:0]  acc_out = 4'd0;
    logic        busy;
    logic        wrap;
    logic [1:0]  last_id;
`ifdef COUNTER_ARBITER_STATS_EN
    logic [31:0] gnt_cnt;
`endif

    counter_arbiter #(.NREQ(4), .WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_val   (req_val),
        .gnt       (gnt),
        .clr_req   (clr_req),
        .acc_reset (acc_reset),
        .acc_in    (acc_in),
        .acc_out   (acc_out),
        .busy      (busy),
        .wrap      (wrap),
        .last_id   (last_id)
`ifdef COUNTER_ARBITER_STATS_EN
        , .gnt_cnt (gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    // The shared counter the arbiter drives.
    always @(posedge clk) begin
        if (acc_reset) acc_out <= 4'd0;
        else           acc_out <= acc_out + acc_in;
    end

    int vec = 0;
    int err = 0;
    int cyc = 0;

    // Requesters: rem[i] grants still wanted, vals[i] their increment.
    int         rem  [4];
    logic [3:0] vals [4];

    logic [3:0] s_gnt, s_acc_in, s_acc_out;
    logic       s_acc_reset, s_busy, s_wrap;
    logic [1:0] s_last_id;

    // Reference model
    int exp_acc, exp_ptr, exp_last;
    bit exp_wrap;
    int grant_cyc [$];
    int grant_idx [$];

    function automatic int rr_next(input logic [3:0] r, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        int sum;
        sum = exp_acc + int'(vals[w]);
        if (sum > 15) exp_wrap = 1'b1;
        exp_acc  = sum % 16;
        exp_ptr  = w;
        exp_last = w;
    endtask

    task automatic model_clear;
        exp_acc  = 0;
        exp_wrap = 1'b0;
    endtask

    task automatic model_reset;
        exp_acc  = 0;
        exp_wrap = 1'b0;
        exp_ptr  = 3;
        exp_last = 0;
    endtask

    task automatic sample;
        @(negedge clk);
        cyc++;
        s_gnt       = gnt;
        s_acc_in    = acc_in;
        s_acc_out   = acc_out;
        s_acc_reset = acc_reset;
        s_busy      = busy;
        s_wrap      = wrap;
        s_last_id   = last_id;
    endtask

    task automatic tick(input logic clr);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (s_gnt[i] && rem[i] > 0) rem[i]--;
            req[i] = (rem[i] > 0);
        end
        req_val = {vals[3], vals[2], vals[1], vals[0]};
        clr_req = clr;
        sample();
    endtask

    task automatic do_clear;
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        model_clear();
    endtask

    function automatic bit all_done;
        for (int i = 0; i < 4; i++) if (rem[i] > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Runs until every requester is served and the arbiter is idle.
    task automatic serve(input int budget);
        int  n;
        int  w;
        int  a;
        bit  chk;
        bit  done;
        n = 0; chk = 0; done = 0;
        while (!done) begin
            tick(1'b0);
            n++;
            if (chk) begin
                vec++;
                if (s_acc_out !== 4'(exp_acc)) begin
                    err++; $display("FAIL acc_after_grant: got %0d expected %0d (cycle %0d)", s_acc_out, exp_acc, cyc);
                end
                chk = 0;
            end
            if (s_gnt !== 4'd0) begin
                w = rr_next(req, exp_ptr);
                vec++;
                if (w < 0 || s_gnt !== 4'(1 << w)) begin
                    err++; $display("FAIL gnt_winner: got %b expected winner %0d (req %b ptr %0d)", s_gnt, w, req, exp_ptr);
                end
                a = -1;
                for (int i = 0; i < 4; i++) if (s_gnt[i]) a = i;
                if (w >= 0) begin
                    vec++;
                    if (s_acc_in !== vals[w]) begin
                        err++; $display("FAIL acc_in: got %0d expected %0d", s_acc_in, vals[w]);
                    end
                    model_grant(w);
                end
                grant_cyc.push_back(cyc);
                grant_idx.push_back(a);
                chk = 1;
            end else if (!s_busy) begin
                vec++;
                if (s_wrap !== exp_wrap || s_last_id !== 2'(exp_last) || s_acc_in !== 4'd0) begin
                    err++; $display("FAIL idle_state: got wrap %b last_id %0d acc_in %0d expected wrap %b last_id %0d acc_in 0",
                                    s_wrap, s_last_id, s_acc_in, exp_wrap, exp_last);
                end
            end
            if (!s_busy && s_gnt === 4'd0 && !chk && all_done()) done = 1;
            if (!done && n >= budget) begin
                vec++; err++;
                $display("FAIL serve_timeout: got no completion after %0d cycles, expected completion", n);
                done = 1;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0; req_val = '0; clr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin rem[i] = 0; vals[i] = '0; end
        s_gnt = '0;
        repeat (2) @(posedge clk);
        sample();
        vec++;
        if (s_acc_reset !== 1'b1 || s_busy !== 1'b1 || s_gnt !== 4'd0 || s_acc_in !== 4'd0 ||
            s_wrap !== 1'b0 || s_last_id !== 2'd0) begin
            err++; $display("FAIL reset_values: got acc_reset %b busy %b gnt %b acc_in %0d wrap %b last_id %0d expected 1 1 0000 0 0 0",
                            s_acc_reset, s_busy, s_gnt, s_acc_in, s_wrap, s_last_id);
        end
        @(posedge clk); #1 reset = 1'b0;
        sample();
        vec++;
        if (s_acc_reset !== 1'b1 || s_busy !== 1'b1) begin
            err++; $display("FAIL init_cycle: got acc_reset %b busy %b expected 1 1", s_acc_reset, s_busy);
        end
        tick(1'b0);
        vec++;
        if (s_acc_reset !== 1'b0 || s_busy !== 1'b0 || s_gnt !== 4'd0 || s_acc_in !== 4'd0 || s_acc_out !== 4'd0) begin
            err++; $display("FAIL idle_after_init: got acc_reset %b busy %b gnt %b acc_in %0d acc_out %0d expected 0 0 0000 0 0",
                            s_acc_reset, s_busy, s_gnt, s_acc_in, s_acc_out);
        end
        model_reset();
    endtask

    task automatic test_round_robin;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        vals[0] = 4'd1; vals[1] = 4'd2; vals[2] = 4'd3; vals[3] = 4'd4;
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        grant_idx.delete(); grant_cyc.delete();
        serve(40);
        vec++;
        if (grant_idx.size() != 5) begin
            err++; $display("FAIL rr_count: got %0d grants expected 5", grant_idx.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vec++;
                if (grant_idx[i] != exp_order[i]) begin
                    err++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grant_idx[i], exp_order[i]);
                end
            end
        end
        vec++;
        if (s_acc_out !== 4'd11 || s_wrap !== 1'b0) begin
            err++; $display("FAIL rr_final: got acc %0d wrap %b expected 11 0", s_acc_out, s_wrap);
        end
    endtask

    task automatic test_single;
        do_clear();
        vals[0] = 4'd3; rem[0] = 3;
        grant_idx.delete(); grant_cyc.delete();
        serve(40);
        vec++;
        if (grant_idx.size() != 3 || s_acc_out !== 4'd9 || s_wrap !== 1'b0) begin
            err++; $display("FAIL single_req: got %0d grants acc %0d wrap %b expected 3 9 0", grant_idx.size(), s_acc_out, s_wrap);
        end
    endtask

    task automatic test_wrap_clear;
        do_clear();
        vals[1] = 4'd14; rem[1] = 1;
        serve(20);
        vec++;
        if (s_acc_out !== 4'd14 || s_wrap !== 1'b0) begin
            err++; $display("FAIL pre_wrap: got acc %0d wrap %b expected 14 0", s_acc_out, s_wrap);
        end
        vals[2] = 4'd3; rem[2] = 1;
        serve(20);
        vec++;
        if (s_acc_out !== 4'd1 || s_wrap !== 1'b1) begin
            err++; $display("FAIL wrap_set: got acc %0d wrap %b expected 1 1", s_acc_out, s_wrap);
        end
        vals[3] = 4'd0; rem[3] = 1;
        serve(20);
        vec++;
        if (s_acc_out !== 4'd1 || s_wrap !== 1'b1) begin
            err++; $display("FAIL wrap_sticky_zero_inc: got acc %0d wrap %b expected 1 1", s_acc_out, s_wrap);
        end
        tick(1'b1);
        tick(1'b0);
        vec++;
        if (s_acc_reset !== 1'b1 || s_busy !== 1'b1) begin
            err++; $display("FAIL clear_pulse: got acc_reset %b busy %b expected 1 1", s_acc_reset, s_busy);
        end
        tick(1'b0);
        vec++;
        if (s_acc_reset !== 1'b0 || s_acc_out !== 4'd0 || s_wrap !== 1'b0 || s_busy !== 1'b0) begin
            err++; $display("FAIL after_clear: got acc_reset %b acc %0d wrap %b busy %b expected 0 0 0 0",
                            s_acc_reset, s_acc_out, s_wrap, s_busy);
        end
        model_clear();
    endtask

    task automatic test_clear_collisions;
        // clear arriving during ISSUE is deferred until the grant completes
        vals[1] = 4'd5; rem[1] = 1;
        tick(1'b0);
        tick(1'b1);
        vec++;
        if (s_gnt !== 4'b0010) begin
            err++; $display("FAIL clr_in_issue_gnt: got %b expected 0010", s_gnt);
        end
        model_grant(1);
        tick(1'b0);
        vec++;
        if (s_acc_out !== 4'd5 || s_acc_reset !== 1'b0) begin
            err++; $display("FAIL clr_in_issue_settle: got acc %0d acc_reset %b expected 5 0", s_acc_out, s_acc_reset);
        end
        tick(1'b0);
        vec++;
        if (s_busy !== 1'b0) begin
            err++; $display("FAIL clr_in_issue_idle: got busy %b expected 0", s_busy);
        end
        tick(1'b0);
        vec++;
        if (s_acc_reset !== 1'b1) begin
            err++; $display("FAIL clr_pending_serviced: got acc_reset %b expected 1", s_acc_reset);
        end
        tick(1'b0);
        vec++;
        if (s_acc_out !== 4'd0 || s_busy !== 1'b0) begin
            err++; $display("FAIL clr_pending_done: got acc %0d busy %b expected 0 0", s_acc_out, s_busy);
        end
        model_clear();

        // clear and request together in IDLE: clear goes first
        vals[2] = 4'd2; rem[2] = 1;
        tick(1'b1);
        tick(1'b0);
        vec++;
        if (s_acc_reset !== 1'b1 || s_gnt !== 4'd0) begin
            err++; $display("FAIL clr_wins: got acc_reset %b gnt %b expected 1 0000", s_acc_reset, s_gnt);
        end
        tick(1'b0);
        tick(1'b0);
        vec++;
        if (s_gnt !== 4'b0100 || s_acc_in !== 4'd2) begin
            err++; $display("FAIL req_after_clr: got gnt %b acc_in %0d expected 0100 2", s_gnt, s_acc_in);
        end
        model_grant(2);
        tick(1'b0);
        vec++;
        if (s_acc_out !== 4'd2) begin
            err++; $display("FAIL req_after_clr_acc: got %0d expected 2", s_acc_out);
        end
        tick(1'b0);

        // clear during CLEAR is absorbed
        tick(1'b1);
        tick(1'b1);
        vec++;
        if (s_acc_reset !== 1'b1) begin
            err++; $display("FAIL absorb_clear: got acc_reset %b expected 1", s_acc_reset);
        end
        tick(1'b0);
        tick(1'b0);
        vec++;
        if (s_busy !== 1'b0 || s_acc_reset !== 1'b0) begin
            err++; $display("FAIL absorb_no_second_clear: got busy %b acc_reset %b expected 0 0", s_busy, s_acc_reset);
        end
        model_clear();
    endtask

    task automatic test_drop;
        vals[3] = 4'd7; rem[3] = 1;
        tick(1'b1);
        rem[3] = 0;
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        vec++;
        if (s_gnt !== 4'd0 || s_busy !== 1'b0 || s_last_id !== 2'(exp_last) || s_acc_out !== 4'd0) begin
            err++; $display("FAIL dropped_req: got gnt %b busy %b last_id %0d acc %0d expected 0000 0 %0d 0",
                            s_gnt, s_busy, s_last_id, s_acc_out, exp_last);
        end
        model_clear();
    endtask

    task automatic test_back_to_back;
        vals[0] = 4'($urandom_range(0, 15)); rem[0] = 4;
        grant_cyc.delete(); grant_idx.delete();
        serve(60);
        vec++;
        if (grant_cyc.size() != 4) begin
            err++; $display("FAIL b2b_count: got %0d expected 4", grant_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                vec++;
                if (grant_cyc[i] - grant_cyc[i-1] != 3) begin
                    err++; $display("FAIL b2b_spacing: got %0d cycles expected 3", grant_cyc[i] - grant_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 4; i++) begin
                if (rem[i] == 0) begin
                    rem[i]  = int'($urandom_range(0, 2));
                    vals[i] = 4'($urandom_range(0, 15));
                end
            end
            serve(200);
            if ($urandom_range(0, 3) == 0) do_clear();
        end
    endtask

    task automatic test_reset_mid;
        vals[1] = 4'd9; rem[1] = 1;
        tick(1'b0);
        tick(1'b0);
        vec++;
        if (s_gnt !== 4'b0010) begin
            err++; $display("FAIL mid_reset_setup: got gnt %b expected 0010", s_gnt);
        end
        #1 reset = 1'b1;
        #1;
        vec++;
        if (gnt !== 4'd0 || acc_in !== 4'd0 || acc_reset !== 1'b1 || busy !== 1'b1) begin
            err++; $display("FAIL mid_reset_drop: got gnt %b acc_in %0d acc_reset %b busy %b expected 0000 0 1 1",
                            gnt, acc_in, acc_reset, busy);
        end
        rem[1] = 0; req = '0; s_gnt = '0;
        @(posedge clk); #1 reset = 1'b0;
        sample();
        tick(1'b0);
        vec++;
        if (s_busy !== 1'b0 || s_last_id !== 2'd0 || s_acc_out !== 4'd0 || s_wrap !== 1'b0) begin
            err++; $display("FAIL mid_reset_recover: got busy %b last_id %0d acc %0d wrap %b expected 0 0 0 0",
                            s_busy, s_last_id, s_acc_out, s_wrap);
        end
        model_reset();
    endtask

`ifdef COUNTER_ARBITER_STATS_EN
    task automatic test_stats;
        vals[0] = 4'd1; rem[0] = 300;
        serve(1000);
        vec++;
        if (gnt_cnt[7:0] !== 8'd255 || gnt_cnt[31:8] !== 24'd0) begin
            err++; $display("FAIL stats_saturate: got %h expected 000000ff", gnt_cnt);
        end
        do_clear();
        vec++;
        if (gnt_cnt !== 32'd0) begin
            err++; $display("FAIL stats_clear: got %h expected 0", gnt_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_wrap_clear();
        test_clear_collisions();
        test_drop();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef COUNTER_ARBITER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
